uart_tx_frame: RTL and testbench

UART transmit framer that serializes one parallel byte per request into a start/data/parity/stop frame on the serial line. Sits directly downstream of the system-controller TX stage, which presents bytes on a level-valid handshake. The byte sources are register-file read data or ALU result halves. This block returns BUSY so the controller can sequence multi-byte responses. CLK is the bit clock: one serial bit per CLK cycle; baud division happens upstream of this block.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_tx_frame_if.sv | 11 +
 rtl/uart_tx_serializer.sv | 31 +++
 rtl/uart_tx_frame.sv | 52 +++++
 tb/tb_uart_tx_frame.sv | 96 +++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, parity selectors and default width for the UART TX framer
package uart_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD = 1'b1;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/uart_tx_frame_if.sv
// uart_tx_frame_if: level-valid byte handshake plus serial line between controller and framer
interface uart_tx_frame_if #(parameter int DATA_WIDTH = uart_pkg::DEF_DATA_WIDTH);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic DATA_VALID;
    logic PAR_EN;
    logic PAR_TYP;
    logic TX_OUT;
    logic BUSY;
    modport master (output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, input TX_OUT, BUSY);
    modport slave (input P_DATA, DATA_VALID, PAR_EN, PAR_TYP, output TX_OUT, BUSY);
endinterface

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: LSB-first shift register with bit counter and last-bit flag
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift_en,
    input  logic                  cnt_clr,
    input  logic                  cnt_en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  lsb,
    output logic                  done
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic [DATA_WIDTH-1:0] sr;
    logic [CW-1:0] cnt;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
            cnt <= '0;
        end else begin
            sr <= load ? data : shift_en ? sr >> 1 : sr;
            cnt <= cnt_clr ? '0 : cnt_en ? cnt + CW'(1) : cnt;
        end
    end
    assign lsb = sr[0];
    assign done = cnt == CW'(DATA_WIDTH - 1);
endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: start/data/parity/stop UART framer, one serial bit per CLK
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input logic CLK,
    input logic rst_n,
    uart_tx_frame_if.slave bus
);
    tx_state_t state, state_next;
    logic par_en_q, par_bit, lsb, done, load, tx_d;
    assign load = state == IDLE && bus.DATA_VALID;
    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .CLK(CLK),
        .rst_n(rst_n),
        .load(load),
        .shift_en(state_next == DATA),
        .cnt_clr(state == START),
        .cnt_en(state == DATA),
        .data(bus.P_DATA),
        .lsb(lsb),
        .done(done)
    );
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = bus.DATA_VALID ? START : IDLE;
            START:   state_next = DATA;
            DATA:    state_next = done ? (par_en_q ? PARITY : STOP) : DATA;
            PARITY:  state_next = STOP;
            default: state_next = IDLE;
        endcase
    end
    // Outputs are registered from the next state so TX_OUT/BUSY line up with the state register
    assign tx_d = state_next == START ? 1'b0 : state_next == DATA ? lsb : state_next == PARITY ? par_bit : 1'b1;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            par_en_q <= 1'b0;
            par_bit <= 1'b0;
            bus.TX_OUT <= 1'b1;
            bus.BUSY <= 1'b0;
        end else begin
            state <= state_next;
            par_en_q <= load ? bus.PAR_EN : par_en_q;
            par_bit <= load ? ^bus.P_DATA ^ (bus.PAR_TYP == PAR_ODD) : par_bit;
            bus.TX_OUT <= tx_d;
            bus.BUSY <= state_next != IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: randomized self-checking bench against a bit-list frame model
module tb_uart_tx_frame;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    always #5 clk = ~clk;
    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();
    uart_tx_frame #(.DATA_WIDTH(8)) dut (.CLK(clk), .rst_n(rst_n), .bus(bus));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, " idle tx"}, 32'(bus.TX_OUT), 1);
        check({tag, " idle busy"}, 32'(bus.BUSY), 0);
    endtask
    // mode 0: drop valid after start, 1: hold valid, 2: scramble inputs mid-frame
    task automatic expect_frame(input logic [7:0] d, input bit pe, input bit pt, input int mode);
        bit f[$];
        f = {1'b0};
        for (int i = 0; i < 8; i++) f.push_back(d[i]);
        if (pe) f.push_back(($countones(d) % 2 == 1) ^ pt);
        f.push_back(1'b1);
        for (int i = 0; i < f.size(); i++) begin
            @(negedge clk);
            check($sformatf("tx[%0d] d=%02h pe=%0d pt=%0d", i, d, pe, pt), 32'(bus.TX_OUT), 32'(f[i]));
            check($sformatf("busy[%0d] d=%02h", i, d), 32'(bus.BUSY), 1);
            if (mode == 0 && i == 0) bus.DATA_VALID = 1'b0;
            if (mode == 2) begin
                bus.P_DATA = 8'($urandom);
                bus.PAR_EN = ~bus.PAR_EN;
                bus.PAR_TYP = 1'($urandom);
                bus.DATA_VALID = i < f.size() - 1 ? 1'($urandom) : 1'b0;
            end
        end
    endtask
    task automatic send(input logic [7:0] d, input bit pe, input bit pt, input int mode);
        bus.P_DATA = d;
        bus.PAR_EN = pe;
        bus.PAR_TYP = pt;
        bus.DATA_VALID = 1'b1;
        expect_frame(d, pe, pt, mode);
        expect_idle($sformatf("after %02h", d));
    endtask
    initial begin
        logic [7:0] d;
        bus.P_DATA = '0;
        bus.DATA_VALID = 1'b0;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(negedge clk);
        check("reset tx", 32'(bus.TX_OUT), 1);
        check("reset busy", 32'(bus.BUSY), 0);
        rst_n = 1'b1;
        expect_idle("post reset");
        send(8'hA5, 1'b0, 1'b0, 0);
        send(8'hA5, 1'b1, 1'b0, 0);
        send(8'hA5, 1'b1, 1'b1, 0);
        send(8'h01, 1'b1, 1'b0, 0);
        send(8'h01, 1'b1, 1'b1, 0);
        bus.P_DATA = 8'h3C;
        bus.PAR_EN = 1'b0;
        bus.DATA_VALID = 1'b1;
        expect_frame(8'h3C, 1'b0, 1'b0, 1);
        expect_idle("gap");
        expect_frame(8'h3C, 1'b0, 1'b0, 0);
        expect_idle("after b2b");
        send(8'hFF, 1'b1, 1'b0, 2);
        send(8'hFF, 1'b0, 1'b1, 2);
        d = 8'h96;
        bus.P_DATA = d;
        bus.PAR_EN = 1'b1;
        bus.DATA_VALID = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("pre-abort tx[%0d]", i), 32'(bus.TX_OUT), i == 0 ? 0 : 32'(d[i-1]));
            bus.DATA_VALID = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort tx", 32'(bus.TX_OUT), 1);
        check("abort busy", 32'(bus.BUSY), 0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("post abort");
        send(8'h55, 1'b1, 1'b1, 0);
        repeat (20) send(8'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 1) * 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
